// File: rtl/write_ctrl.sv
// rtl/write_ctrl.sv - Write2dev executor: UART bytes to BRAM A/B elements
//
// Purpose:
//   When en_write rises, latches bram_sel and gathers N_ELEMS little-endian
//   elements of DATA_W bits from the UART byte stream. Each element is written
//   to BRAM A or B with a one-cycle write-enable pulse. write_done pulses once
//   the vector is complete (or aborted), so the decoder can return to WAIT.
//
// Optional feature macro: WRITE_TIMEOUT_EN (idle-byte timeout abort; raises
//   write_err together with write_done). Undefined: RECV waits forever.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   en_write, bram_sel    command level and target select from decoder
//   rx_ready, rx_data     byte strobe and byte from UART receiver
//   bram_we_a, bram_we_b  per-element write strobes (mutually exclusive)
//   bram_addr, bram_din   write address / data
//   busy                  high from RECV entry until back in IDLE
//   write_done, write_err completion pulse and timeout-abort flag

module write_ctrl #(
  parameter int N_ELEMS        = 1024,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  localparam int ADDR_W        = $clog2(N_ELEMS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_write,
  input  logic              bram_sel,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              bram_we_a,
  output logic              bram_we_b,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              busy,
  output logic              write_done,
  output logic              write_err
);

  localparam int BYTES  = (DATA_W + 7) / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    FLUSH   = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t state, state_next;

  logic                sel_q;
  logic [BCNT_W-1:0]   byte_cnt;
  logic [ADDR_W-1:0]   elem_cnt;
  logic [BYTES*8-1:0]  shreg;
  logic [BYTES*8-1:0]  assembled;
  logic                last_byte;
  logic                last_elem;
  logic                timeout_hit;

  // Element as it would look with the incoming byte dropped into its slot.
  always_comb begin
    assembled = shreg;
    assembled[byte_cnt*8 +: 8] = rx_data;
  end

  assign last_byte = (byte_cnt == BCNT_W'(BYTES - 1));
  assign last_elem = (elem_cnt == ADDR_W'(N_ELEMS - 1));

`ifdef WRITE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // A byte arriving in the same cycle as expiry wins over the abort.
  assign timeout_hit = (state == RECV) && !rx_ready &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state != RECV || rx_ready) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en_write) state_next = RECV;
      RECV: begin
        if (rx_ready && last_byte && last_elem) state_next = FLUSH;
        else if (timeout_hit)                   state_next = DONE;
      end
      FLUSH:   state_next = DONE;
      DONE:    state_next = RELEASE;
      // Wait for the command level to drop so a held en_write cannot restart.
      RELEASE: if (!en_write) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q      <= 1'b0;
      byte_cnt   <= '0;
      elem_cnt   <= '0;
      shreg      <= '0;
      bram_we_a  <= 1'b0;
      bram_we_b  <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      busy       <= 1'b0;
      write_done <= 1'b0;
      write_err  <= 1'b0;
    end else begin
      bram_we_a  <= 1'b0;
      bram_we_b  <= 1'b0;
      busy       <= (state_next != IDLE);
      write_done <= (state_next == DONE);
      write_err  <= timeout_hit;

      case (state)
        IDLE: begin
          if (en_write) begin
            sel_q     <= bram_sel;
            byte_cnt  <= '0;
            elem_cnt  <= '0;
            shreg     <= '0;
            bram_addr <= '0;
          end
        end
        RECV: begin
          if (rx_ready) begin
            if (last_byte) begin
              bram_din  <= assembled[DATA_W-1:0];
              bram_addr <= elem_cnt;
              bram_we_a <= ~sel_q;
              bram_we_b <= sel_q;
              byte_cnt  <= '0;
              shreg     <= '0;
              // Hold at the last index rather than wrapping to 0.
              if (!last_elem) elem_cnt <= elem_cnt + ADDR_W'(1);
            end else begin
              shreg    <= assembled;
              byte_cnt <= byte_cnt + BCNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_write_ctrl.sv
// tb/tb_write_ctrl.sv - directed self-checking bench for write_ctrl

module tb_write_ctrl;

  localparam int N_ELEMS = 4;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              en_write;
  logic              bram_sel;
  logic              rx_ready;
  logic [7:0]        rx_data;
  logic              bram_we_a;
  logic              bram_we_b;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              busy;
  logic              write_done;
  logic              write_err;

  write_ctrl #(
    .N_ELEMS        (N_ELEMS),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en_write   (en_write),
    .bram_sel   (bram_sel),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .bram_we_a  (bram_we_a),
    .bram_we_b  (bram_we_b),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .busy       (busy),
    .write_done (write_done),
    .write_err  (write_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Write log captured by the monitor.
  logic        w_sel  [$];
  logic [1:0]  w_addr [$];
  logic [15:0] w_din  [$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int cyc      = 0;
  int last_we_cyc = 0;
  int done_cyc    = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bram_we_a && bram_we_b) both_cnt = both_cnt + 1;
    if (bram_we_a || bram_we_b) begin
      w_sel.push_back(bram_we_b);
      w_addr.push_back(bram_addr);
      w_din.push_back(bram_din);
      last_we_cyc = cyc;
    end
    if (write_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (write_err) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_log();
    w_sel.delete();
    w_addr.delete();
    w_din.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic check_vec(input string tag, input logic sel,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] exp_d [4];
    exp_d = '{e0, e1, e2, e3};
    check({tag, " nwrites"}, w_din.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < w_din.size()) begin
        check($sformatf("%s sel%0d", tag, i), w_sel[i], sel);
        check($sformatf("%s addr%0d", tag, i), w_addr[i], i);
        check($sformatf("%s din%0d", tag, i), w_din[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    logic [7:0] v1 [8];
    logic [7:0] v2 [8];
    v1 = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
    v2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    reset = 1'b1; en_write = 1'b0; bram_sel = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;

    // 1: reset state
    tick(2);
    check("rst we_a", bram_we_a, 0);
    check("rst we_b", bram_we_b, 0);
    check("rst addr", bram_addr, 0);
    check("rst din", bram_din, 0);
    check("rst busy", busy, 0);
    check("rst done", write_done, 0);
    check("rst err", write_err, 0);
    reset = 1'b0;
    tick(2);

    // 2: spaced bytes into BRAM A
    clear_log();
    bram_sel = 1'b0; en_write = 1'b1;
    tick(1);
    check("t2 busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      send_byte(v1[i]);
      tick(1);
    end
    tick(4);
    check_vec("t2", 1'b0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    check("t2 done", done_cnt, 1);
    check("t2 done lat", done_cyc - last_we_cyc, 1);
    check("t2 err", err_cnt, 0);
    check("t2 busy rel", busy, 1);
    en_write = 1'b0;
    tick(2);
    check("t2 busy idle", busy, 0);

    // 3: BRAM B, select toggles mid-transfer
    clear_log();
    bram_sel = 1'b1; en_write = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      send_byte(v1[i]);
      if (i == 2) bram_sel = 1'b0;
      tick(1);
    end
    tick(4);
    check_vec("t3", 1'b1, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    check("t3 done", done_cnt, 1);
    en_write = 1'b0;
    tick(2);

    // 4: back-to-back strobes, then a byte during DONE
    clear_log();
    en_write = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      rx_data = v2[i]; rx_ready = 1'b1;
      tick(1);
    end
    rx_ready = 1'b0;
    tick(1);
    check("t4 done now", write_done, 1);
    send_byte(8'hAA);
    tick(3);
    check_vec("t4", 1'b0, 16'h2211, 16'h4433, 16'h6655, 16'h8877);
    check("t4 done", done_cnt, 1);
    check("t4 done lat", done_cyc - last_we_cyc, 1);
    en_write = 1'b0;
    tick(2);

    // 5: reset mid-transfer, then fresh command; held en_write blocks restart
    clear_log();
    en_write = 1'b1;
    tick(1);
    send_byte(8'hEE); send_byte(8'hDD); send_byte(8'hCC);
    reset = 1'b1; en_write = 1'b0;
    tick(1);
    reset = 1'b0;
    check("t5 busy rst", busy, 0);
    check("t5 nw rst", w_din.size(), 1);
    clear_log();
    en_write = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) send_byte(v2[i]);
    tick(4);
    check_vec("t5", 1'b0, 16'h2211, 16'h4433, 16'h6655, 16'h8877);
    tick(10);
    send_byte(8'h01); send_byte(8'h02);
    tick(3);
    check("t5 no retrig nw", w_din.size(), 4);
    check("t5 no retrig done", done_cnt, 1);
    check("t5 busy held", busy, 1);
    en_write = 1'b0;
    tick(2);
    check("t5 busy idle", busy, 0);

    // 6: stall after 5 bytes
    clear_log();
    en_write = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) send_byte(v1[i]);
    tick(60);
    check("t6 nwrites", w_din.size(), 2);
`ifdef WRITE_TIMEOUT_EN
    check("t6 done", done_cnt, 1);
    check("t6 err", err_cnt, 1);
`else
    check("t6 done", done_cnt, 0);
    check("t6 err", err_cnt, 0);
    check("t6 busy", busy, 1);
`endif
    reset = 1'b1;
    tick(2);
    reset = 1'b0;

    check("we exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
